// File: rtl/program_loader.sv
// Program memory loader: accepts a framed byte stream (LEN, 2*LEN data bytes
// high-first, CHK) and writes 16-bit words to program memory from address 0.
// The core is held in reset until a load completes with a matching checksum.
module program_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MAX_WORDS = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [5:0]        words_loaded
);

  localparam logic [7:0] MaxWordsByte = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StWr,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e            r_state;
  logic [5:0]        r_len;
  logic [7:0]        r_hi;
  logic [7:0]        r_chk;
  logic              r_pm_we;
  logic [ADDR_W-1:0] r_pm_addr;
  logic [15:0]       r_pm_wdata;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [5:0]        r_words_loaded;

  logic              w_xfer;
  logic [5:0]        w_words_next;

  // Byte acceptance is decoded straight from state so the host sees it this cycle.
  always_comb begin
    in_ready = 1'b0;
    unique case (r_state)
      StLen, StHi, StLo, StChk: in_ready = 1'b1;
      default:                  in_ready = 1'b0;
    endcase
  end

  assign w_xfer       = in_valid && in_ready;
  assign w_words_next = r_words_loaded + 6'd1;

  // Loader FSM with all status and write-port outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= StIdle;
      r_len          <= '0;
      r_hi           <= '0;
      r_chk          <= '0;
      r_pm_we        <= 1'b0;
      r_pm_addr      <= '0;
      r_pm_wdata     <= '0;
      r_cpu_reset    <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      unique case (r_state)
        // Idle, Done and Err all accept a new load request the same way.
        StIdle, StDone, StErr: begin
          if (start) begin
            r_state        <= StLen;
            r_cpu_reset    <= 1'b1;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
            r_pm_addr      <= '0;
            r_chk          <= '0;
          end
        end
        StLen: begin
          if (w_xfer) begin
            r_len <= in_data[5:0];
            r_chk <= in_data;
            if (in_data > MaxWordsByte) begin
              r_state <= StErr;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else if (in_data == 8'd0) begin
              r_state <= StChk;
            end else begin
              r_state <= StHi;
            end
          end
        end
        StHi: begin
          if (w_xfer) begin
            r_hi    <= in_data;
            r_chk   <= r_chk ^ in_data;
            r_state <= StLo;
          end
        end
        StLo: begin
          if (w_xfer) begin
            r_pm_wdata <= {r_hi, in_data};
            r_chk      <= r_chk ^ in_data;
            r_pm_we    <= 1'b1;
            r_state    <= StWr;
          end
        end
        // Single write cycle; the address advances only after the word lands.
        StWr: begin
          r_pm_we        <= 1'b0;
          r_pm_addr      <= r_pm_addr + ADDR_W'(1);
          r_words_loaded <= w_words_next;
          if (w_words_next == r_len) begin
            r_state <= StChk;
          end else begin
            r_state <= StHi;
          end
        end
        StChk: begin
          if (w_xfer) begin
            r_busy <= 1'b0;
            if (in_data == r_chk) begin
              r_state     <= StDone;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= StErr;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign pm_we        = r_pm_we;
  assign pm_addr      = r_pm_addr;
  assign pm_wdata     = r_pm_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule
